cbi980_stream_sched: RTL and testbench
======================================

// Module: cbi980_stream_sched
// PURPOSE
//  Scheduler that owns the register port of the cbi980 codec core and moves audio between two streams and the core FIFOs.
//  It brings the core up, enables the channels, then polls SR and services one FIFO per poll.
//  RX channels are served round-robin; TX words come from a channel-tagged input stream.
//  It also clears overflow/underflow flags and reports them as sticky errors.
// PARAMETERS
//  POLL_GAP   2   idle cycles inserted after each SR poll that finds nothing to service (0..15)
// PORTS
//  clk          in   1   core clock
//  rst          in   1   asynchronous, active-high reset
//  en           in   1   1: run service loop; 0: disable channels and idle
//  rxen_cfg     in   2   RX channel enables written to CR[5:4]
//  txen_cfg     in   2   TX channel enables written to CR[3:2]
//  s_tx_valid   in   1   TX word available
//  s_tx_ready   out  1   TX word accepted (1-cycle pulse)
//  s_tx_ch      in   1   TX target channel (1: DOUT1R, 0: DOUT0R)
//  s_tx_data    in   32  TX sample
//  m_rx_valid   out  1   RX word held in output register
//  m_rx_ready   in   1   downstream accepts RX word
//  m_rx_ch      out  1   channel of RX word
//  m_rx_data    out  32  RX sample
//  core_wr_addr out  3   to core wr_addr
//  core_wr_data out  32  to core wr_data
//  core_wr_en   out  1   to core wr_en
//  core_wr_err  in   1   from core wr_err
//  core_rd_addr out  3   to core rd_addr
//  core_rd_vld  out  1   to core rd_valid_in
//  core_rd_data in   32  from core rd_data
//  core_rd_ack  in   1   from core rd_valid_out
//  running      out  1   init seen and CR enables written
//  err_sticky   out  3   {wr_err, any rx_ovf, any tx_unf}; cleared only by rst
// BEHAVIOUR
//  Reset values
//  - All outputs are 0; FSM is in INIT_RD; RR pointer = 1; the RX output register is empty.
//  Core timing
//  - A read drives core_rd_addr with core_rd_vld=1 for exactly 1 cycle.
//  - core_rd_data is valid in the cycle core_rd_ack=1, which is the next cycle.
//  - A DIN read pops the core FIFO on the issue edge.
//  - A write drives core_wr_en=1 for exactly 1 cycle.
//  - At most one core access is outstanding at any time.
//  SR decode
//  - bit 31 = init.
//  - rxne1 = SR[15], txnf1 = SR[13], rxne0 = SR[11], txnf0 = SR[9].
//  - ovf = SR[19] | SR[17]; unf = SR[18] | SR[16].
//  FSM
//  - INIT_RD: read SR (addr 1) -> INIT_WT.
//  - INIT_WT: on ack, if init=1 -> CFG, else -> INIT_RD.
//  - CFG: write CR (addr 2) = {12'b0, ie=12'b0, 2'b0, rxen_cfg, txen_cfg, 2'b00}; set running -> POLL.
//  - POLL: if en=0 -> STOP; else read SR -> SR_WT.
//  - SR_WT: on ack, evaluate in priority order:
//    1. ovf|unf: -> CLR.
//    2. RX candidate: channel rxne with rxen set AND output register empty, chosen from the RR pointer.
//       Issue a read of DIN1R (6) or DIN0R (7) -> RX_WT. Toggle RR to the other channel only when it is served.
//    3. s_tx_valid and txnf[s_tx_ch] and txen_cfg[s_tx_ch] -> TX.
//    4. Otherwise -> GAP.
//  - RX_WT: on ack, load m_rx_data/m_rx_ch and set m_rx_valid -> POLL.
//  - TX: write DOUT1R (4) or DOUT0R (5) with s_tx_data; pulse s_tx_ready in the same cycle -> POLL.
//  - CLR: write CR with bit 1 set and the same enables; set err_sticky bits from the captured SR -> POLL.
//  - GAP: wait POLL_GAP cycles -> POLL. POLL_GAP=0 goes straight to POLL.
//  - STOP: write CR with all enables 0; clear running -> IDLE.
//  - IDLE: when en=1 -> CFG.
//  RX output register
//  - Cleared when m_rx_valid & m_rx_ready.
//  - Never overwritten: RX is not selected while it is full, so there is no drop path.
//  - Draining and loading never coincide, because a load happens only when the register is already empty.
//  Other rules
//  - RX takes priority over TX in the same poll, which prevents core RX overflow.
//  - TX waits if the selected channel FIFO is full; s_tx_data must hold while s_tx_valid=1.
//  - core_wr_err=1 in any cycle sets err_sticky[2].
//  - en deasserting mid-access: the current access completes; the FSM goes to STOP at the next POLL.
//  - Async rst mid-operation: outputs drop to their reset values immediately; a partial RX word is discarded.
// TESTING
//  1. Bring-up: core init=0 for 5 SR reads, then 1.
//     -> Exactly one CR write with data 0x0000_003C for rxen=txen=2'b11; running=1.
//  2. TX: push 4 words 0xA0..0xA3 on ch1.
//     -> 4 writes to addr 4 in order, each preceded by an SR read; s_tx_ready pulses 4 times.
//  3. RX round-robin: SR shows rxne1=rxne0=1 constantly, m_rx_ready=1.
//     -> m_rx_ch sequence alternates 1,0,1,0 starting with 1.
//  4. Backpressure: m_rx_ready=0 with rxne set.
//     -> exactly 1 DIN read is issued; TX is still served. After m_rx_ready=1 the next DIN read follows.
//  5. Error: SR[19]=1 once.
//     -> CR write 0x0000_003E (enables + bit 1); err_sticky=3'b010, still set after 100 cycles.
//  6. en=0 during RX_WT.
//     -> read completes and data is delivered; then CR write 0x0; running=0; no further core accesses.

Source files
------------

// File: rtl/cbi980_stream_sched.sv
// cbi980_stream_sched: sole owner of the cbi980 core register port. Brings the core up,
// then polls SR and moves at most one word per poll between the core FIFOs and the streams.
//
// state   | meaning
// INIT_RD | issue SR read while waiting for core init
// INIT_WT | wait for SR read data, loop until init=1
// CFG     | CR enable write in flight, raise running
// POLL    | issue SR read, or head to STOP when en=0
// SR_WT   | wait for SR; pick clear / RX / TX / gap
// RX_WT   | DIN read outstanding, load RX output register
// TX      | DOUT write and s_tx_ready pulse in flight
// CLR     | CR write with flag-clear bit in flight
// GAP     | idle cycles after an empty poll
// STOP    | CR disable write in flight, drop running
// IDLE    | wait for en, then reconfigure
module cbi980_stream_sched #(
    parameter int unsigned POLL_GAP = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  rxen_cfg,
    input  logic [1:0]  txen_cfg,
    input  logic        s_tx_valid,
    output logic        s_tx_ready,
    input  logic        s_tx_ch,
    input  logic [31:0] s_tx_data,
    output logic        m_rx_valid,
    input  logic        m_rx_ready,
    output logic        m_rx_ch,
    output logic [31:0] m_rx_data,
    output logic [2:0]  core_wr_addr,
    output logic [31:0] core_wr_data,
    output logic        core_wr_en,
    input  logic        core_wr_err,
    output logic [2:0]  core_rd_addr,
    output logic        core_rd_vld,
    input  logic [31:0] core_rd_data,
    input  logic        core_rd_ack,
    output logic        running,
    output logic [2:0]  err_sticky
);

    localparam logic [2:0] A_SR    = 3'd1;
    localparam logic [2:0] A_CR    = 3'd2;
    localparam logic [2:0] A_DOUT1 = 3'd4;
    localparam logic [2:0] A_DOUT0 = 3'd5;
    localparam logic [2:0] A_DIN1  = 3'd6;
    localparam logic [2:0] A_DIN0  = 3'd7;
    localparam logic [3:0] GAP_LOAD = 4'(POLL_GAP) - 4'd1;

    typedef enum logic [3:0] {
        S_INIT_RD,
        S_INIT_WT,
        S_CFG,
        S_POLL,
        S_SR_WT,
        S_RX_WT,
        S_TX,
        S_CLR,
        S_GAP,
        S_STOP,
        S_IDLE
    } state_t;

    state_t      state_q;
    logic        rr_q;
    logic        rx_pend_ch_q;
    logic [3:0]  gap_q;
    logic [1:0]  rxen_q;
    logic [1:0]  txen_q;
    logic        s_tx_ready_q;
    logic        m_rx_valid_q;
    logic        m_rx_ch_q;
    logic [31:0] m_rx_data_q;
    logic [2:0]  wr_addr_q;
    logic [31:0] wr_data_q;
    logic        wr_en_q;
    logic [2:0]  rd_addr_q;
    logic        rd_vld_q;
    logic        running_q;
    logic [2:0]  err_q;

    logic       sr_init;
    logic       sr_ovf;
    logic       sr_unf;
    logic       rx1_rdy;
    logic       rx0_rdy;
    logic [1:0] sr_txnf;
    logic       rx_go;
    logic       rx_ch_d;
    logic       tx_go;

    function automatic logic [31:0] cr_word(logic [1:0] rxen, logic [1:0] txen, logic clr);
        return {26'b0, rxen, txen, clr, 1'b0};
    endfunction

    always_comb begin
        sr_init = core_rd_data[31];
        sr_ovf  = core_rd_data[19] | core_rd_data[17];
        sr_unf  = core_rd_data[18] | core_rd_data[16];
        rx1_rdy = core_rd_data[15] & rxen_q[1];
        rx0_rdy = core_rd_data[11] & rxen_q[0];
        sr_txnf = {core_rd_data[13], core_rd_data[9]};
        // RX only when the output register is free, so a loaded word is never overwritten
        rx_go   = ~m_rx_valid_q & (rx1_rdy | rx0_rdy);
        if (rr_q) begin
            rx_ch_d = rx1_rdy;
        end else begin
            rx_ch_d = ~rx0_rdy;
        end
        tx_go = s_tx_valid & sr_txnf[s_tx_ch] & txen_q[s_tx_ch];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_INIT_RD;
            rr_q         <= 1'b1;
            rx_pend_ch_q <= 1'b0;
            gap_q        <= 4'd0;
            rxen_q       <= 2'b00;
            txen_q       <= 2'b00;
            s_tx_ready_q <= 1'b0;
            m_rx_valid_q <= 1'b0;
            m_rx_ch_q    <= 1'b0;
            m_rx_data_q  <= 32'h0;
            wr_addr_q    <= 3'd0;
            wr_data_q    <= 32'h0;
            wr_en_q      <= 1'b0;
            rd_addr_q    <= 3'd0;
            rd_vld_q     <= 1'b0;
            running_q    <= 1'b0;
            err_q        <= 3'b000;
        end else begin
            rd_vld_q     <= 1'b0;
            wr_en_q      <= 1'b0;
            s_tx_ready_q <= 1'b0;
            if (core_wr_err) begin
                err_q[2] <= 1'b1;
            end
            if (m_rx_valid_q && m_rx_ready) begin
                m_rx_valid_q <= 1'b0;
            end

            case (state_q)
                S_INIT_RD: begin
                    rd_addr_q <= A_SR;
                    rd_vld_q  <= 1'b1;
                    state_q   <= S_INIT_WT;
                end
                S_INIT_WT: begin
                    if (core_rd_ack) begin
                        if (sr_init) begin
                            rxen_q    <= rxen_cfg;
                            txen_q    <= txen_cfg;
                            wr_addr_q <= A_CR;
                            wr_data_q <= cr_word(rxen_cfg, txen_cfg, 1'b0);
                            wr_en_q   <= 1'b1;
                            state_q   <= S_CFG;
                        end else begin
                            state_q <= S_INIT_RD;
                        end
                    end
                end
                S_CFG: begin
                    running_q <= 1'b1;
                    state_q   <= S_POLL;
                end
                S_POLL: begin
                    if (!en) begin
                        rxen_q    <= 2'b00;
                        txen_q    <= 2'b00;
                        wr_addr_q <= A_CR;
                        wr_data_q <= cr_word(2'b00, 2'b00, 1'b0);
                        wr_en_q   <= 1'b1;
                        state_q   <= S_STOP;
                    end else begin
                        rd_addr_q <= A_SR;
                        rd_vld_q  <= 1'b1;
                        state_q   <= S_SR_WT;
                    end
                end
                S_SR_WT: begin
                    if (core_rd_ack) begin
                        if (sr_ovf || sr_unf) begin
                            wr_addr_q <= A_CR;
                            wr_data_q <= cr_word(rxen_q, txen_q, 1'b1);
                            wr_en_q   <= 1'b1;
                            if (sr_ovf) begin
                                err_q[1] <= 1'b1;
                            end
                            if (sr_unf) begin
                                err_q[0] <= 1'b1;
                            end
                            state_q <= S_CLR;
                        end else if (rx_go) begin
                            rd_addr_q    <= rx_ch_d ? A_DIN1 : A_DIN0;
                            rd_vld_q     <= 1'b1;
                            rx_pend_ch_q <= rx_ch_d;
                            rr_q         <= ~rx_ch_d;
                            state_q      <= S_RX_WT;
                        end else if (tx_go) begin
                            wr_addr_q    <= s_tx_ch ? A_DOUT1 : A_DOUT0;
                            wr_data_q    <= s_tx_data;
                            wr_en_q      <= 1'b1;
                            s_tx_ready_q <= 1'b1;
                            state_q      <= S_TX;
                        end else if (POLL_GAP == 0) begin
                            state_q <= S_POLL;
                        end else begin
                            gap_q   <= GAP_LOAD;
                            state_q <= S_GAP;
                        end
                    end
                end
                S_RX_WT: begin
                    if (core_rd_ack) begin
                        m_rx_data_q  <= core_rd_data;
                        m_rx_ch_q    <= rx_pend_ch_q;
                        m_rx_valid_q <= 1'b1;
                        state_q      <= S_POLL;
                    end
                end
                S_TX, S_CLR: begin
                    state_q <= S_POLL;
                end
                S_GAP: begin
                    if (gap_q == 4'd0) begin
                        state_q <= S_POLL;
                    end else begin
                        gap_q <= gap_q - 4'd1;
                    end
                end
                S_STOP: begin
                    running_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
                S_IDLE: begin
                    if (en) begin
                        rxen_q    <= rxen_cfg;
                        txen_q    <= txen_cfg;
                        wr_addr_q <= A_CR;
                        wr_data_q <= cr_word(rxen_cfg, txen_cfg, 1'b0);
                        wr_en_q   <= 1'b1;
                        state_q   <= S_CFG;
                    end
                end
                default: begin
                    state_q <= S_INIT_RD;
                end
            endcase
        end
    end

    assign s_tx_ready   = s_tx_ready_q;
    assign m_rx_valid   = m_rx_valid_q;
    assign m_rx_ch      = m_rx_ch_q;
    assign m_rx_data    = m_rx_data_q;
    assign core_wr_addr = wr_addr_q;
    assign core_wr_data = wr_data_q;
    assign core_wr_en   = wr_en_q;
    assign core_rd_addr = rd_addr_q;
    assign core_rd_vld  = rd_vld_q;
    assign running      = running_q;
    assign err_sticky   = err_q;

endmodule

// File: tb/tb_cbi980_stream_sched.sv
// tb_cbi980_stream_sched: behavioural cbi980 core model driving the scheduler, with
// expected core writes and RX words queued at stimulus time and checked by a monitor.
`timescale 1ns/1ps
module tb_cbi980_stream_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [1:0]  rxen_cfg = 2'b11;
    logic [1:0]  txen_cfg = 2'b11;
    logic        s_tx_valid = 1'b0;
    logic        s_tx_ready;
    logic        s_tx_ch = 1'b0;
    logic [31:0] s_tx_data = 32'h0;
    logic        m_rx_valid;
    logic        m_rx_ready = 1'b1;
    logic        m_rx_ch;
    logic [31:0] m_rx_data;
    logic [2:0]  core_wr_addr;
    logic [31:0] core_wr_data;
    logic        core_wr_en;
    logic        core_wr_err = 1'b0;
    logic [2:0]  core_rd_addr;
    logic        core_rd_vld;
    logic [31:0] core_rd_data = 32'h0;
    logic        core_rd_ack = 1'b0;
    logic        running;
    logic [2:0]  err_sticky;

    int checks = 0;
    int errors = 0;

    logic [34:0] exp_wr[$];
    logic [32:0] exp_rx[$];
    logic [32:0] tx_src[$];
    logic [31:0] fifo1[$];
    logic [31:0] fifo0[$];
    int sr_reads = 0;
    int din_reads = 0;
    int acc_count = 0;
    int ready_cnt = 0;
    bit ovf_flag = 0;
    bit txnf_rand = 0;
    bit din_issue = 0;
    int model_rr = 1;

    cbi980_stream_sched #(.POLL_GAP(2)) dut (
        .clk(clk), .rst(rst), .en(en), .rxen_cfg(rxen_cfg), .txen_cfg(txen_cfg),
        .s_tx_valid(s_tx_valid), .s_tx_ready(s_tx_ready), .s_tx_ch(s_tx_ch), .s_tx_data(s_tx_data),
        .m_rx_valid(m_rx_valid), .m_rx_ready(m_rx_ready), .m_rx_ch(m_rx_ch), .m_rx_data(m_rx_data),
        .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data), .core_wr_en(core_wr_en),
        .core_wr_err(core_wr_err), .core_rd_addr(core_rd_addr), .core_rd_vld(core_rd_vld),
        .core_rd_data(core_rd_data), .core_rd_ack(core_rd_ack), .running(running),
        .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    // Core: read data returned one cycle after the request; TX source advances on ready.
    initial begin : core_model
        logic        pend;
        logic [31:0] pend_data;
        logic [31:0] sr;
        pend = 1'b0;
        pend_data = 32'h0;
        forever begin
            @(negedge clk);
            core_rd_ack  = pend;
            core_rd_data = pend ? pend_data : 32'h0;
            pend = 1'b0;
            if (core_rd_vld) begin
                acc_count++;
                pend = 1'b1;
                case (core_rd_addr)
                    3'd1: begin
                        sr = 32'h0;
                        sr[31] = (sr_reads >= 5);
                        sr[15] = (fifo1.size() > 0);
                        sr[11] = (fifo0.size() > 0);
                        sr[13] = txnf_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
                        sr[9]  = txnf_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
                        sr[19] = ovf_flag;
                        pend_data = sr;
                        sr_reads++;
                    end
                    3'd6: begin
                        pend_data = (fifo1.size() > 0) ? fifo1.pop_front() : 32'hBAD0_0001;
                        din_reads++;
                        din_issue = 1;
                    end
                    3'd7: begin
                        pend_data = (fifo0.size() > 0) ? fifo0.pop_front() : 32'hBAD0_0000;
                        din_reads++;
                        din_issue = 1;
                    end
                    default: pend_data = 32'hDEAD_BEEF;
                endcase
            end
            if (core_wr_en) begin
                acc_count++;
                if (core_wr_addr == 3'd2 && core_wr_data[1]) ovf_flag = 0;
            end
            if (s_tx_valid && s_tx_ready) begin
                void'(tx_src.pop_front());
                ready_cnt++;
            end
            s_tx_valid = (tx_src.size() > 0);
            if (s_tx_valid) {s_tx_ch, s_tx_data} = tx_src[0];
        end
    end

    initial begin : monitor
        logic [2:0]  last_rd;
        bit          last_was_rd;
        logic [34:0] e;
        logic [32:0] r;
        last_rd = 3'd0;
        last_was_rd = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (core_rd_vld) begin
                    last_was_rd = 1;
                    last_rd = core_rd_addr;
                end
                if (core_wr_en) begin
                    checks++;
                    if (exp_wr.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write got addr=%0d data=%h required no write", core_wr_addr, core_wr_data);
                    end else begin
                        e = exp_wr.pop_front();
                        if ({core_wr_addr, core_wr_data} !== e) begin
                            errors++;
                            $display("FAIL core_write got addr=%0d data=%h required addr=%0d data=%h",
                                     core_wr_addr, core_wr_data, e[34:32], e[31:0]);
                        end
                    end
                    if (core_wr_addr == 3'd4 || core_wr_addr == 3'd5) begin
                        checks++;
                        if (!(last_was_rd && last_rd == 3'd1)) begin
                            errors++;
                            $display("FAIL tx_after_sr got last_read=%0d required 1", last_rd);
                        end
                        checks++;
                        if (s_tx_ready !== 1'b1) begin
                            errors++;
                            $display("FAIL tx_ready_with_write got %b required 1", s_tx_ready);
                        end
                    end
                    last_was_rd = 0;
                end
                if (m_rx_valid && m_rx_ready) begin
                    checks++;
                    if (exp_rx.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_rx got ch=%0d data=%h required none", m_rx_ch, m_rx_data);
                    end else begin
                        r = exp_rx.pop_front();
                        if ({m_rx_ch, m_rx_data} !== r) begin
                            errors++;
                            $display("FAIL rx_word got ch=%0d data=%h required ch=%0d data=%h",
                                     m_rx_ch, m_rx_data, r[32], r[31:0]);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog got timeout required finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h required %h", name, got, want);
        end
    endtask

    function automatic bit pending();
        return (exp_wr.size() > 0) || (exp_rx.size() > 0) || (tx_src.size() > 0);
    endfunction

    task automatic wait_drain(input string name, input int max);
        int n;
        n = 0;
        while (pending() && n < max) begin
            tick(1);
            n++;
        end
        checks++;
        if (pending()) begin
            errors++;
            $display("FAIL %s got pending wr=%0d rx=%0d tx=%0d required all 0",
                     name, exp_wr.size(), exp_rx.size(), tx_src.size());
        end
    endtask

    // Fill both core RX FIFOs at once; expected order is round-robin from the pointer,
    // moving the pointer to the other channel after each word served.
    function automatic void load_rx(input int n1, input int n0);
        logic [31:0] q1[$];
        logic [31:0] q0[$];
        logic [31:0] w;
        int ch;
        for (int i = 0; i < n1; i++) begin
            w = $urandom;
            fifo1.push_back(w);
            q1.push_back(w);
        end
        for (int i = 0; i < n0; i++) begin
            w = $urandom;
            fifo0.push_back(w);
            q0.push_back(w);
        end
        while (q1.size() > 0 || q0.size() > 0) begin
            if (model_rr == 1) ch = (q1.size() > 0) ? 1 : 0;
            else               ch = (q0.size() > 0) ? 0 : 1;
            if (ch == 1) exp_rx.push_back({1'b1, q1.pop_front()});
            else         exp_rx.push_back({1'b0, q0.pop_front()});
            model_rr = 1 - ch;
        end
    endfunction

    initial begin : main
        int base;
        int n;
        int ntx;
        logic [31:0] w;
        logic ch;

        tick(3);
        check("reset_ctrl", {running, m_rx_valid, s_tx_ready, core_wr_en, core_rd_vld,
                             err_sticky, m_rx_ch, core_wr_addr, core_rd_addr}, 64'h0);
        check("reset_data", {m_rx_data, core_wr_data}, 64'h0);

        exp_wr.push_back({3'd2, 32'h0000_003C});
        rst = 1'b0;
        wait_drain("bringup", 300);
        tick(3);
        check("running_after_cfg", running, 1);
        check("init_reads_before_cfg", (sr_reads >= 6), 1);

        base = ready_cnt;
        for (int i = 0; i < 4; i++) begin
            w = 32'hA0 + i;
            tx_src.push_back({1'b1, w});
            exp_wr.push_back({3'd4, w});
        end
        wait_drain("tx_phase", 400);
        check("tx_ready_count", ready_cnt - base, 4);

        load_rx(4, 4);
        wait_drain("rx_round_robin", 400);

        m_rx_ready = 1'b0;
        base = din_reads;
        load_rx(2, 2);
        w = $urandom;
        tx_src.push_back({1'b0, w});
        exp_wr.push_back({3'd5, w});
        tick(80);
        check("bp_din_reads", din_reads - base, 1);
        check("bp_tx_served", exp_wr.size(), 0);
        check("bp_rx_held", m_rx_valid, 1);
        m_rx_ready = 1'b1;
        tick(12);
        check("bp_next_din", (din_reads - base) >= 2, 1);
        wait_drain("bp_drain", 400);

        exp_wr.push_back({3'd2, 32'h0000_003E});
        ovf_flag = 1;
        wait_drain("ovf_clear", 200);
        tick(2);
        check("err_after_ovf", err_sticky, 3'b010);
        tick(100);
        check("err_sticky_hold", err_sticky, 3'b010);

        core_wr_err = 1'b1;
        tick(1);
        core_wr_err = 1'b0;
        tick(2);
        check("err_after_wr_err", err_sticky, 3'b110);

        txnf_rand = 1;
        for (int round = 0; round < 3; round++) begin
            load_rx($urandom_range(0, 5), $urandom_range(0, 5));
            ntx = $urandom_range(4, 8);
            for (int i = 0; i < ntx; i++) begin
                ch = 1'($urandom_range(0, 1));
                w = $urandom;
                tx_src.push_back({ch, w});
                exp_wr.push_back({(ch ? 3'd4 : 3'd5), w});
            end
            n = 0;
            while (pending() && n < 2000) begin
                m_rx_ready = 1'($urandom_range(0, 1));
                tick(1);
                n++;
            end
            m_rx_ready = 1'b1;
            wait_drain("random_mix", 200);
        end
        txnf_rand = 0;
        check("err_after_random", err_sticky, 3'b110);

        din_issue = 0;
        exp_wr.push_back({3'd2, 32'h0});
        load_rx(0, 1);
        n = 0;
        while (!din_issue && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("din_issue_seen", din_issue, 1);
        en = 1'b0;
        wait_drain("stop_phase", 200);
        tick(4);
        check("running_after_stop", running, 0);
        base = acc_count;
        tick(50);
        check("no_access_after_stop", acc_count - base, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
